uart_rx: RTL

Serial receiver for the UART device: recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the `rx` pin. Received bytes are queued in a small receive FIFO that the device register layer drains with a read strobe. It uses the same clocks-per-bit divider as the transmit path, so one baud register programs both directions. It reports framing and overrun errors as sticky flags.

---
 rtl/uart_rx.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer, a
// clocks-per-bit divider latched at the start edge, a small first-word-
// fall-through receive FIFO, and sticky framing/overrun flags.
module uart_rx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [15:0]   clock_divider,
    input  logic          rx,
    input  logic          read_en,
    input  logic          clear_errors,
    output logic [7:0]    data_out,
    output logic          data_valid,
    output logic [CW-1:0] fifo_count,
    output logic          busy,
    output logic          framing_error,
    output logic          overrun
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Synchronizer and receiver datapath
    logic        rx_meta;
    logic        rxs;
    logic [2:0]  state;
    logic [2:0]  state_d;
    logic [15:0] div;
    logic [15:0] div_d;
    logic [15:0] cnt;
    logic [15:0] cnt_d;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_d;
    logic [7:0]  shift;
    logic [7:0]  shift_d;
    logic        cnt_zero_c;
    logic        push_c;
    logic        frame_err_c;

    // FIFO storage and control
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_d;
    logic          full_c;
    logic          pop_c;
    logic          wr_c;
    logic          drop_c;

    // Two-flop synchronizer on the asynchronous serial line, idling high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            div     <= 16'd0;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            div     <= div_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

    assign cnt_zero_c = (cnt == 16'd0);

    // Next-state logic: each sample point is where the down-counter hits zero
    always_comb begin
        state_d     = state;
        div_d       = div;
        cnt_d       = cnt;
        bit_idx_d   = bit_idx;
        shift_d     = shift;
        push_c      = 1'b0;
        frame_err_c = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    // div is not latched yet, so half comes from the live input
                    div_d   = clock_divider;
                    cnt_d   = (clock_divider >> 1) - 16'd1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_zero_c) begin
                    if (!rxs) begin
                        cnt_d     = div - 16'd1;
                        bit_idx_d = 3'd0;
                        state_d   = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_zero_c) begin
                    shift_d[bit_idx] = rxs;
                    cnt_d            = div - 16'd1;
                    bit_idx_d        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_zero_c) begin
                    if (rxs) begin
                        push_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            ST_BREAK: begin
                // Hold here while the line stays low so a break cannot retrigger
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign full_c = (fifo_count == CW'(FIFO_DEPTH));
    assign pop_c  = read_en && data_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign wr_c   = push_c && (!full_c || pop_c);
    assign drop_c = push_c && full_c && !pop_c;

    // Occupancy next value
    always_comb begin
        count_d = fifo_count;
        case ({wr_c, pop_c})
            2'b10:   count_d = fifo_count + CW'(1);
            2'b01:   count_d = fifo_count - CW'(1);
            default: count_d = fifo_count;
        endcase
    end

    // FIFO pointers, storage and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_valid <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
        end else begin
            if (wr_c) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_d;
            data_valid <= (count_d != '0);
        end
    end

    // Sticky error flags; a new error in the clear cycle wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (frame_err_c) begin
                framing_error <= 1'b1;
            end else if (clear_errors) begin
                framing_error <= 1'b0;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end else if (clear_errors) begin
                overrun <= 1'b0;
            end
        end
    end

    // First-word-fall-through head read, forced to zero when empty
    assign data_out = data_valid ? mem[rd_ptr] : 8'h00;

endmodule
